instr_fetch_ctrl: RTL and testbench

- Sequences instruction fetch for the 16-bit processor. It owns the program counter and drives the combinational instruction ROM address.
- Captures each ROM word into an instruction register, which it presents to decode with a valid/ready handshake.
- Applies jump/branch redirects from execute and supports run/halt control.
- Sits between the instruction ROM and the decode stage.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/instr_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg                                                          |
// | Shared types and defaults for the instruction fetch controller:   |
// | FSM state encoding, bus width defaults, reset PC and NOP word.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fetch_pkg;

  // Encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_e;

  localparam int          PC_W_DEFAULT     = 8;
  localparam int          INSTR_W_DEFAULT  = 16;
  localparam logic [7:0]  RESET_PC_DEFAULT = 8'h00;
  localparam logic [15:0] NOP              = 16'h0000;
  localparam logic [15:0] FETCH_COUNT_MAX  = 16'hFFFF;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_ctrl                                                   |
// | Owns the program counter, addresses the combinational instruction |
// | ROM, captures words into the instruction register and hands them  |
// | to decode with valid/ready. Handles redirects and run/halt.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter int              INSTR_W  = INSTR_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               run,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [1:0]         state,
  output logic [15:0]        fetch_count
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic [15:0]        fetch_count_q, fetch_count_d;
  logic               load;

  // Next-state logic: redirect wins over everything, then per-state control.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_valid_d    = ir_valid_q;
    fetch_count_d = fetch_count_q;
    load          = 1'b0;

    if (redirect_valid) begin
      // The ROM word addressed this cycle belongs to the old stream; drop it.
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
      if (state_q == ST_DRAIN) begin
        state_d = ST_HALTED;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (halt_req) begin
            // An instruction stuck on backpressure must still reach decode.
            if (ir_valid_q && !ir_ready) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_HALTED;
            end
          end else if (!ir_valid_q || ir_ready) begin
            load = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (ir_ready) begin
            state_d = ST_HALTED;
          end
        end
        ST_HALTED: begin
          if (run && !halt_req) begin
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (load) begin
        ir_d       = rom_data;
        ir_pc_d    = pc_q;
        ir_valid_d = 1'b1;
        pc_d       = pc_q + PC_W'(1);
        if (fetch_count_q != FETCH_COUNT_MAX) begin
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end else if (ir_valid_q && ir_ready) begin
        ir_valid_d = 1'b0;
      end
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= INSTR_W'(NOP);
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_valid_q    <= ir_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign state       = state_q;
  assign fetch_count = fetch_count_q;

endmodule : instr_fetch_ctrl
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_fetch_ctrl                                                |
// | Directed self-checking bench for instr_fetch_ctrl with a small    |
// | combinational ROM model.                                           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        run;
  logic        halt_req;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [1:0]  state;
  logic [15:0] fetch_count;

  int errors = 0;
  int checks = 0;

  logic [15:0] prog [0:5];

  instr_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .run            (run),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .state          (state),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // ROM model
  always_comb begin
    rom_data = 16'h0000;
    if (rom_addr < 8'd6) rom_data = prog[rom_addr[2:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 8'h00; ir_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %h expected %h", state, 2'b00); end
    checks++; if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir: got %h expected %h", ir, 16'h0000); end
    checks++; if (ir_pc !== 8'h00) begin errors++; $display("FAIL reset_ir_pc: got %h expected %h", ir_pc, 8'h00); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid: got %b expected 0", ir_valid); end
    checks++; if (rom_addr !== 8'h00) begin errors++; $display("FAIL reset_rom_addr: got %h expected %h", rom_addr, 8'h00); end
    checks++; if (fetch_count !== 16'h0) begin errors++; $display("FAIL reset_fetch_count: got %h expected 0", fetch_count); end
    // Without run, the block must stay idle.
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL idle_hold: got %h expected 00", state); end
  endtask

  task automatic test_fetch_stream();
    ir_ready = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL start_state: got %h expected 01", state); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL start_bubble: got %b expected 0", ir_valid); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (ir !== prog[i]) begin errors++; $display("FAIL stream_ir[%0d]: got %h expected %h", i, ir, prog[i]); end
      checks++; if (ir_pc !== 8'(i)) begin errors++; $display("FAIL stream_ir_pc[%0d]: got %h expected %h", i, ir_pc, 8'(i)); end
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, ir_valid); end
    end
    checks++; if (fetch_count !== 16'd6) begin errors++; $display("FAIL stream_count: got %0d expected 6", fetch_count); end
  endtask

  task automatic test_backpressure();
    // Steer back to address 1 so AA09 sits in ir.
    redirect_valid = 1'b1; redirect_pc = 8'h01;
    tick();
    redirect_valid = 1'b0;
    checks++; if (ir_valid !== 1'b0 || rom_addr !== 8'h01) begin errors++; $display("FAIL bp_redirect: got valid=%b addr=%h expected valid=0 addr=01", ir_valid, rom_addr); end
    tick();
    checks++; if (ir !== 16'hAA09 || ir_pc !== 8'h01) begin errors++; $display("FAIL bp_setup: got ir=%h pc=%h expected ir=aa09 pc=01", ir, ir_pc); end
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ir !== 16'hAA09 || ir_pc !== 8'h01 || rom_addr !== 8'h02 || ir_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got ir=%h pc=%h addr=%h valid=%b expected ir=aa09 pc=01 addr=02 valid=1", i, ir, ir_pc, rom_addr, ir_valid); end
      checks++; if (fetch_count !== 16'd7) begin errors++; $display("FAIL bp_count[%0d]: got %0d expected 7", i, fetch_count); end
    end
    ir_ready = 1'b1;
    tick();
    checks++; if (ir !== 16'hA009 || ir_pc !== 8'h02) begin errors++; $display("FAIL bp_release: got ir=%h pc=%h expected ir=a009 pc=02", ir, ir_pc); end
    checks++; if (fetch_count !== 16'd8) begin errors++; $display("FAIL bp_release_count: got %0d expected 8", fetch_count); end
  endtask

  task automatic test_redirect();
    tick(); tick();
    checks++; if (ir !== 16'hA800) begin errors++; $display("FAIL rd_setup: got %h expected a800", ir); end
    redirect_valid = 1'b1; redirect_pc = 8'h02;
    tick();
    redirect_valid = 1'b0;
    checks++; if (ir_valid !== 1'b0 || rom_addr !== 8'h02) begin errors++; $display("FAIL rd_bubble: got valid=%b addr=%h expected valid=0 addr=02", ir_valid, rom_addr); end
    checks++; if (fetch_count !== 16'd10) begin errors++; $display("FAIL rd_flush_count: got %0d expected 10", fetch_count); end
    tick();
    checks++; if (ir !== 16'hA009 || ir_pc !== 8'h02 || ir_valid !== 1'b1) begin errors++; $display("FAIL rd_target: got ir=%h pc=%h valid=%b expected ir=a009 pc=02 valid=1", ir, ir_pc, ir_valid); end
    checks++; if (fetch_count !== 16'd11) begin errors++; $display("FAIL rd_count: got %0d expected 11", fetch_count); end
  endtask

  task automatic test_drain_halt();
    ir_ready = 1'b0; halt_req = 1'b1;
    tick();
    checks++; if (state !== 2'b10 || ir_valid !== 1'b1) begin errors++; $display("FAIL drain_enter: got state=%h valid=%b expected state=10 valid=1", state, ir_valid); end
    tick();
    checks++; if (state !== 2'b10 || rom_addr !== 8'h03) begin errors++; $display("FAIL drain_hold: got state=%h addr=%h expected state=10 addr=03", state, rom_addr); end
    ir_ready = 1'b1;
    tick();
    checks++; if (state !== 2'b11 || ir_valid !== 1'b0 || rom_addr !== 8'h03) begin errors++; $display("FAIL drain_exit: got state=%h valid=%b addr=%h expected state=11 valid=0 addr=03", state, ir_valid, rom_addr); end
    // halt_req must dominate run while halted.
    run = 1'b1;
    tick();
    checks++; if (state !== 2'b11) begin errors++; $display("FAIL halt_priority: got %h expected 11", state); end
    halt_req = 1'b0;
    tick();
    run = 1'b0;
    checks++; if (state !== 2'b01 || ir_valid !== 1'b0) begin errors++; $display("FAIL resume_state: got state=%h valid=%b expected state=01 valid=0", state, ir_valid); end
    tick();
    checks++; if (ir !== 16'h2802 || ir_pc !== 8'h03 || fetch_count !== 16'd12) begin errors++; $display("FAIL resume_load: got ir=%h pc=%h cnt=%0d expected ir=2802 pc=03 cnt=12", ir, ir_pc, fetch_count); end
    // Halt with decode ready: handoff completes, no load, straight to HALTED.
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    checks++; if (state !== 2'b11 || ir_valid !== 1'b0 || rom_addr !== 8'h04 || fetch_count !== 16'd12) begin
      errors++; $display("FAIL halt_direct: got state=%h valid=%b addr=%h cnt=%0d expected state=11 valid=0 addr=04 cnt=12", state, ir_valid, rom_addr, fetch_count); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect_valid = 1'b0;
    checks++; if (state !== 2'b11 || rom_addr !== 8'hFF) begin errors++; $display("FAIL wrap_redirect: got state=%h addr=%h expected state=11 addr=ff", state, rom_addr); end
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    checks++; if (ir !== 16'h0000 || ir_pc !== 8'hFF || ir_valid !== 1'b1) begin errors++; $display("FAIL wrap_ff: got ir=%h pc=%h valid=%b expected ir=0000 pc=ff valid=1", ir, ir_pc, ir_valid); end
    tick();
    checks++; if (ir !== 16'hD000 || ir_pc !== 8'h00 || rom_addr !== 8'h01) begin errors++; $display("FAIL wrap_00: got ir=%h pc=%h addr=%h expected ir=d000 pc=00 addr=01", ir, ir_pc, rom_addr); end
    checks++; if (fetch_count !== 16'd14) begin errors++; $display("FAIL wrap_count: got %0d expected 14", fetch_count); end
  endtask

  task automatic test_reset_in_drain();
    ir_ready = 1'b0; halt_req = 1'b1;
    tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL rst_drain_setup: got %h expected 10", state); end
    reset = 1'b1;
    tick();
    reset = 1'b0; halt_req = 1'b0;
    checks++; if (state !== 2'b00 || ir_valid !== 1'b0 || rom_addr !== 8'h00 || fetch_count !== 16'd0 || ir !== 16'h0000) begin
      errors++; $display("FAIL rst_drain: got state=%h valid=%b addr=%h cnt=%0d ir=%h expected state=00 valid=0 addr=00 cnt=0 ir=0000", state, ir_valid, rom_addr, fetch_count, ir); end
  endtask

  task automatic test_saturation();
    ir_ready = 1'b1; run = 1'b1;
    tick();
    run = 1'b0;
    repeat (65534) tick();
    checks++; if (fetch_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", fetch_count); end
    tick();
    checks++; if (fetch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", fetch_count); end
    repeat (10) tick();
    checks++; if (fetch_count !== 16'hFFFF || ir_valid !== 1'b1) begin errors++; $display("FAIL sat_hold: got cnt=%h valid=%b expected cnt=ffff valid=1", fetch_count, ir_valid); end
  endtask

  initial begin
    prog[0] = 16'hD000; prog[1] = 16'hAA09; prog[2] = 16'hA009;
    prog[3] = 16'h2802; prog[4] = 16'hA800; prog[5] = 16'h9A89;
    test_reset();
    test_fetch_stream();
    test_backpressure();
    test_redirect();
    test_drain_halt();
    test_wrap();
    test_reset_in_drain();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_instr_fetch_ctrl
`default_nettype wire
